// File: rtl/bosc_ctrl_pkg.sv
// bosc_ctrl_pkg: ship states, direction/keycode constants and key decode shared by the control stages
package bosc_ctrl_pkg;

    typedef enum logic [1:0] {SPAWN, FLY, EXPLODE, GAME_OVER} ship_state_t;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_NONE  = 4'b0000;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // unrecognised keys keep the current heading so the ship never stops mid-flight
    function automatic logic [3:0] key_to_dir(input logic [7:0] key, input logic [3:0] cur);
        return key == KEY_W ? DIR_UP :
               key == KEY_S ? DIR_DOWN :
               key == KEY_D ? DIR_RIGHT :
               key == KEY_A ? DIR_LEFT : cur;
    endfunction

endpackage

// File: rtl/ship_heading_ctrl_if.sv
// ship_heading_ctrl_if: input events and renderer-facing outputs of the ship heading controller
interface ship_heading_ctrl_if;

    logic       frame_clk;
    logic [7:0] keycode;
    logic       collided;
    logic [3:0] direction;
    logic       bg_reset;
    logic [2:0] lives;
    logic       game_over;

    modport master (
        output frame_clk, keycode, collided,
        input  direction, bg_reset, lives, game_over
    );

    modport slave (
        input  frame_clk, keycode, collided,
        output direction, bg_reset, lives, game_over
    );

endinterface

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: 2-flop synchroniser plus registered rising-edge pulse, 3 clk edges after the async rise
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic tick_o
);

    // [1:0] synchronise, [2] holds the previous synchronised level
    logic [2:0] sync_q;
    logic       tick_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/ship_heading_ctrl.sv
// ship_heading_ctrl: ship life-cycle FSM turning keycodes and collisions into heading, bg_reset and lives
module ship_heading_ctrl
    import bosc_ctrl_pkg::*;
#(
    parameter int SPAWN_FRAMES   = 60,
    parameter int EXPLODE_FRAMES = 90,
    parameter int LIVES          = 3
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    ship_heading_ctrl_if.slave bus
);

    localparam int MAX_FRAMES = SPAWN_FRAMES > EXPLODE_FRAMES ? SPAWN_FRAMES : EXPLODE_FRAMES;
    localparam int CW         = MAX_FRAMES > 1 ? $clog2(MAX_FRAMES) : 1;

    logic          frame_tick;
    ship_state_t   state_q, state_d;
    logic [3:0]    dir_q, dir_d;
    logic          bg_q, bg_d;
    logic [2:0]    lives_q, lives_d;
    logic          go_q, go_d;
    logic [CW-1:0] cnt_q, cnt_d;

    frame_tick_sync u_sync (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .async_i(bus.frame_clk),
        .tick_o (frame_tick)
    );

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SPAWN;
            dir_q   <= DIR_NONE;
            bg_q    <= 1'b1;
            lives_q <= 3'(LIVES);
            go_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            bg_q    <= bg_d;
            lives_q <= lives_d;
            go_q    <= go_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        bg_d    = bg_q;
        lives_d = lives_q;
        go_d    = go_q;
        cnt_d   = (frame_tick && (state_q == SPAWN || state_q == EXPLODE)) ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            SPAWN: if (frame_tick && cnt_q == CW'(SPAWN_FRAMES - 1)) begin
                state_d = FLY;
                dir_d   = DIR_UP;
                bg_d    = 1'b0;
            end
            // collision wins over a same-cycle tick; lives >= 1 is guaranteed on FLY entry
            FLY: if (bus.collided) begin
                state_d = EXPLODE;
                dir_d   = DIR_NONE;
                bg_d    = 1'b1;
                lives_d = lives_q - 3'd1;
            end else if (frame_tick) begin
                dir_d = key_to_dir(bus.keycode, dir_q);
            end
            EXPLODE: if (frame_tick && cnt_q == CW'(EXPLODE_FRAMES - 1)) begin
                state_d = lives_q == 3'd0 ? GAME_OVER : SPAWN;
                go_d    = lives_q == 3'd0;
            end
            GAME_OVER: if (frame_tick && bus.keycode == KEY_ENTER) begin
                state_d = SPAWN;
                lives_d = 3'(LIVES);
                go_d    = 1'b0;
            end
            default: ;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    assign bus.direction = dir_q;
    assign bus.bg_reset  = bg_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = go_q;

endmodule

// File: tb/tb_ship_heading_ctrl.sv
// tb_ship_heading_ctrl: directed tick table, reset/collision corner sequences and random run against a spec-level model
module tb_ship_heading_ctrl;

    localparam int S = 2;
    localparam int E = 3;
    localparam int L = 2;
    localparam int M_SPAWN = 0, M_FLY = 1, M_EXPL = 2, M_GO = 3;

    typedef struct {
        logic [7:0] pre;
        logic [7:0] key;
        logic       coll;
        logic [3:0] dir;
        logic       bg;
        logic [2:0] lives;
        logic       go;
    } rec_t;

    logic vga_clk;
    logic reset_n;
    int   vectors = 0;
    int   errors  = 0;

    int         ms, mrem, mlives;
    logic [3:0] mdir;
    bit         fcq[$];
    rec_t       tbl[20];

    ship_heading_ctrl_if bus ();

    ship_heading_ctrl #(.SPAWN_FRAMES(S), .EXPLODE_FRAMES(E), .LIVES(L)) u_dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] dir_of(input logic [7:0] k, input logic [3:0] cur);
        case (k)
            8'h1A:   return 4'b1000;
            8'h16:   return 4'b0100;
            8'h07:   return 4'b0010;
            8'h04:   return 4'b0001;
            default: return cur;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        ms     = M_SPAWN;
        mrem   = S;
        mdir   = 4'b0000;
        mlives = L;
        fcq    = '{0, 0, 0, 0, 0};
    endtask

    // a tick acts at edge n when frame_clk was sampled 1 at edge n-3 and 0 at edge n-4
    task automatic model_step();
        bit tick;
        fcq.push_front(bus.frame_clk);
        void'(fcq.pop_back());
        tick = fcq[3] && !fcq[4];
        if (ms == M_FLY && bus.collided) begin
            ms = M_EXPL; mrem = E; mdir = 4'b0000; mlives--;
        end else if (tick) begin
            case (ms)
                M_SPAWN: begin
                    mrem--;
                    if (mrem == 0) begin ms = M_FLY; mdir = 4'b1000; end
                end
                M_FLY: mdir = dir_of(bus.keycode, mdir);
                M_EXPL: begin
                    mrem--;
                    if (mrem == 0) begin ms = (mlives == 0) ? M_GO : M_SPAWN; mrem = S; end
                end
                default: if (bus.keycode == 8'h28) begin ms = M_SPAWN; mrem = S; mlives = L; end
            endcase
        end
    endtask

    task automatic cyc();
        if (!reset_n) model_reset(); else model_step();
        @(posedge vga_clk);
        #1;
        chk("direction", 8'(bus.direction), 8'(mdir));
        chk("bg_reset", 8'(bus.bg_reset), 8'(ms != M_FLY));
        chk("lives", 8'(bus.lives), 8'(mlives));
        chk("game_over", 8'(bus.game_over), 8'(ms == M_GO));
    endtask

    // low phase with pre-key, then a frame_clk rise; returns just after the edge where the tick acts
    task automatic pulse(input logic [7:0] pre, input logic [7:0] key, input logic coll);
        bus.keycode   = pre;
        bus.frame_clk = 1'b0;
        repeat (3) cyc();
        bus.keycode   = key;
        bus.frame_clk = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("frame_tick", 8'(u_dut.frame_tick), 8'(i == 3));
        end
        if (coll) bus.collided = 1'b1;
        cyc();
    endtask

    task automatic run_rec(input rec_t r, input int idx);
        pulse(r.pre, r.key, r.coll);
        chk($sformatf("rec%0d dir", idx), 8'(bus.direction), 8'(r.dir));
        chk($sformatf("rec%0d bg", idx), 8'(bus.bg_reset), 8'(r.bg));
        chk($sformatf("rec%0d lives", idx), 8'(bus.lives), 8'(r.lives));
        chk($sformatf("rec%0d go", idx), 8'(bus.game_over), 8'(r.go));
        if (r.coll) begin
            repeat (4) cyc();
            bus.collided = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] keys[7];
        int hold;
        tbl = '{
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd2, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h8, 1'b0, 3'd2, 1'b0},
            '{8'h00, 8'h07, 1'b0, 4'h2, 1'b0, 3'd2, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h2, 1'b0, 3'd2, 1'b0},
            '{8'h00, 8'h04, 1'b0, 4'h1, 1'b0, 3'd2, 1'b0},
            '{8'h1A, 8'h00, 1'b0, 4'h1, 1'b0, 3'd2, 1'b0},
            '{8'h00, 8'h16, 1'b1, 4'h0, 1'b1, 3'd1, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h8, 1'b0, 3'd1, 1'b0},
            '{8'h00, 8'h00, 1'b1, 4'h0, 1'b1, 3'd0, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd0, 1'b1},
            '{8'h00, 8'h00, 1'b1, 4'h0, 1'b1, 3'd0, 1'b1},
            '{8'h00, 8'h28, 1'b0, 4'h0, 1'b1, 3'd2, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 3'd2, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'h8, 1'b0, 3'd2, 1'b0}
        };
        reset_n       = 1'b0;
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        bus.collided  = 1'b0;
        model_reset();
        repeat (2) @(posedge vga_clk);
        #1;
        chk("reset dir", 8'(bus.direction), 8'h00);
        chk("reset bg", 8'(bus.bg_reset), 8'h01);
        chk("reset lives", 8'(bus.lives), 8'h02);
        chk("reset go", 8'(bus.game_over), 8'h00);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) run_rec(tbl[i], i + 1);

        // asynchronous reset in the middle of EXPLODE, between clock edges
        pulse(8'h00, 8'h00, 1'b1);
        chk("pre-reset lives", 8'(bus.lives), 8'h01);
        cyc();
        cyc();
        bus.collided = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async dir", 8'(bus.direction), 8'h00);
        chk("async bg", 8'(bus.bg_reset), 8'h01);
        chk("async lives", 8'(bus.lives), 8'h02);
        chk("async go", 8'(bus.game_over), 8'h00);
        model_reset();
        cyc();
        reset_n = 1'b1;
        pulse(8'h00, 8'h00, 1'b0);
        pulse(8'h00, 8'h00, 1'b0);
        chk("respawn dir", 8'(bus.direction), 8'h08);
        chk("respawn bg", 8'(bus.bg_reset), 8'h00);

        // collided held high from SPAWN onwards
        reset_n = 1'b0;
        cyc();
        bus.collided = 1'b1;
        reset_n      = 1'b1;
        pulse(8'h00, 8'h00, 1'b0);
        pulse(8'h00, 8'h00, 1'b0);
        chk("held fly dir", 8'(bus.direction), 8'h08);
        chk("held fly lives", 8'(bus.lives), 8'h02);
        cyc();
        chk("held hit dir", 8'(bus.direction), 8'h00);
        chk("held hit lives", 8'(bus.lives), 8'h01);
        repeat (3) pulse(8'h00, 8'h00, 1'b0);
        chk("held spawn lives", 8'(bus.lives), 8'h01);
        repeat (2) pulse(8'h00, 8'h00, 1'b0);
        chk("held refly dir", 8'(bus.direction), 8'h08);
        cyc();
        chk("held rehit lives", 8'(bus.lives), 8'h00);
        repeat (3) pulse(8'h00, 8'h00, 1'b0);
        chk("held over go", 8'(bus.game_over), 8'h01);
        bus.collided = 1'b0;

        // random traffic against the model
        keys = '{8'h00, 8'h1A, 8'h16, 8'h07, 8'h04, 8'h28, 8'h55};
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                bus.frame_clk = ~bus.frame_clk;
                hold = $urandom_range(1, 6);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) begin
                keys[6]     = 8'($urandom);
                bus.keycode = keys[$urandom_range(0, 6)];
            end
            bus.collided = ($urandom_range(0, 30) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
